noc_sync_injector: RTL and testbench

Clocked front-end that feeds one node's `dg` generator port of the 16-node 4-D hypercube NoC. It accepts {destination, payload} words from synchronous client logic over a valid/ready interface and buffers them in a small FIFO. Packets addressed to the injector's own node are discarded. Surviving words are driven onto the node's 8-bit four-phase bundled-data generator channel, one packet per full handshake. There is one instance per node, between the client and `dg_in[k]`.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/noc_sync_fifo.sv | 48 ++++
 rtl/noc_sync_injector.sv | 99 +++++++++
 tb/tb_noc_sync_injector.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared widths, packet layout and injector state encoding for the hypercube NoC
package noc_pkg;

    localparam int NODE_ADDR_W = 4;
    localparam int PAYLOAD_W   = 4;
    localparam int DG_W        = 8;

    typedef struct packed {
        logic [NODE_ADDR_W-1:0] dest;
        logic [PAYLOAD_W-1:0]   payload;
    } dg_pkt_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO
    } inj_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: DEPTH-entry synchronous packet FIFO with registered occupancy
module noc_sync_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_wr_en,
    input  dg_pkt_t i_wr_data,
    input  logic    i_rd_en,
    output dg_pkt_t o_rd_data,
    output logic    o_full,
    output logic    o_empty
);

    localparam int AW = $clog2(DEPTH);

    dg_pkt_t       r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full    = r_count == (AW+1)'(DEPTH);
    assign o_empty   = r_count == '0;
    assign w_pop     = i_rd_en && !o_empty;
    assign w_push    = i_wr_en && (!o_full || w_pop);
    assign o_rd_data = r_mem[r_rd_ptr];

    // storage write; contents are qualified by the count so need no reset
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk)
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end

endmodule

// File: rtl/noc_sync_injector.sv
// noc_sync_injector: buffers client words and drives them onto a node's four-phase generator channel
module noc_sync_injector
    import noc_pkg::*;
#(
    parameter logic [NODE_ADDR_W-1:0] MY_IP = 4'b0000,
    parameter int                     DEPTH = 4,
    parameter int                     CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [NODE_ADDR_W-1:0] in_dest,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    output logic                   in_ready,
    output logic                   dg_req,
    output logic [DG_W-1:0]        dg_data,
    input  logic                   dg_ack,
    output logic [CNT_W-1:0]       sent_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);

    logic [1:0]       r_ack_sync;
    inj_state_e       r_state;
    logic             r_req;
    dg_pkt_t          r_data;
    logic [CNT_W-1:0] r_sent;
    logic [CNT_W-1:0] r_drop;

    logic             w_full;
    logic             w_empty;
    logic             w_ack_s;
    logic             w_accept;
    logic             w_self;
    logic             w_pop;
    dg_pkt_t          w_wr_data;
    dg_pkt_t          w_rd_data;

    assign in_ready  = !w_full;
    assign w_accept  = in_valid && in_ready;
    assign w_self    = in_dest == MY_IP;
    assign w_pop     = r_state == IDLE && !w_empty;
    assign w_ack_s   = r_ack_sync[1];
    assign w_wr_data = {in_dest, in_payload};
    assign dg_req    = r_req;
    assign dg_data   = r_data;
    assign sent_cnt  = r_sent;
    assign drop_cnt  = r_drop;

    noc_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_accept && !w_self),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // two-flop synchronizer: the asynchronous ack is only ever seen through ack_s
    always_ff @(posedge clk)
        if (!rst_n) r_ack_sync <= 2'b00;
        else r_ack_sync <= {r_ack_sync[0], dg_ack};

    // handshake sequencer: data loaded one cycle ahead of req for bundling margin
    always_ff @(posedge clk)
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_sent  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_pop) begin
                    r_data  <= w_rd_data;
                    r_state <= SETUP;
                end
                SETUP: begin
                    r_req   <= 1'b1;
                    r_state <= REQ_HI;
                end
                REQ_HI: if (w_ack_s) begin
                    r_req   <= 1'b0;
                    r_state <= REQ_LO;
                end
                REQ_LO: if (!w_ack_s) begin
                    r_sent  <= r_sent + CNT_W'(~&r_sent);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end

    // self-addressed words are consumed without storage and counted, saturating
    always_ff @(posedge clk)
        if (!rst_n) r_drop <= '0;
        else if (w_accept && w_self) r_drop <= r_drop + CNT_W'(~&r_drop);

endmodule

// File: tb/tb_noc_sync_injector.sv
// tb_noc_sync_injector: directed bench with a queue-based reference model and node emulators
module tb_noc_sync_injector;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_dest = '0;
    logic [3:0]  in_payload = '0;
    logic        in_ready;
    logic        dg_req;
    logic [7:0]  dg_data;
    logic        dg_ack = 1'b0;
    logic [15:0] sent_cnt;
    logic [15:0] drop_cnt;

    logic        b_valid = 1'b0;
    logic [3:0]  b_dest = '0;
    logic [3:0]  b_payload = '0;
    logic        b_ready;
    logic        b_req;
    logic [7:0]  b_data;
    logic        b_ack = 1'b0;
    logic [1:0]  b_sent;
    logic [1:0]  b_drop;

    int checks = 0;
    int failures = 0;

    noc_sync_injector #(.MY_IP(4'd0), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_dest(in_dest),
        .in_payload(in_payload), .in_ready(in_ready), .dg_req(dg_req),
        .dg_data(dg_data), .dg_ack(dg_ack), .sent_cnt(sent_cnt), .drop_cnt(drop_cnt)
    );

    noc_sync_injector #(.MY_IP(4'd5), .DEPTH(DEPTH), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_dest(b_dest),
        .in_payload(b_payload), .in_ready(b_ready), .dg_req(b_req),
        .dg_data(b_data), .dg_ack(b_ack), .sent_cnt(b_sent), .drop_cnt(b_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- node emulators ----------------
    int         a_dly = 0;
    bit         a_hold = 1'b0;
    int         a_cnt = 0;
    logic [7:0] a_log[$];
    logic [7:0] b_log[$];

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            dg_ack = 1'b0;
            a_cnt = 0;
        end else if (!dg_ack && dg_req && !a_hold) begin
            if (a_cnt >= a_dly) begin
                dg_ack = 1'b1;
                a_log.push_back(dg_data);
                a_cnt = 0;
            end else a_cnt++;
        end else if (dg_ack && !dg_req) dg_ack = 1'b0;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) b_ack = 1'b0;
        else if (!b_ack && b_req) begin
            b_ack = 1'b1;
            b_log.push_back(b_data);
        end else if (b_ack && !b_req) b_ack = 1'b0;
    end

    // ---------------- reference model of dut ----------------
    logic [7:0]  m_q[$];
    int          m_leg = 0;
    logic        m_req = 1'b0;
    logic [7:0]  m_data = '0;
    logic [15:0] m_sent = '0;
    logic [15:0] m_drop = '0;
    logic [1:0]  m_ack_pipe = '0;
    bit          m_on = 1'b0;
    bit          m_acks;
    bit          m_acc;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_leg = 0;
            m_req = 1'b0;
            m_data = '0;
            m_sent = '0;
            m_drop = '0;
            m_ack_pipe = '0;
            m_on = 1'b1;
        end else begin
            m_acks = m_ack_pipe[1];
            m_acc = in_valid && (m_q.size() < DEPTH);
            m_ack_pipe = {m_ack_pipe[0], dg_ack};
            if (m_leg == 0) begin
                if (m_q.size() > 0) begin
                    m_data = m_q.pop_front();
                    m_leg = 1;
                end
            end else if (m_leg == 1) begin
                m_req = 1'b1;
                m_leg = 2;
            end else if (m_leg == 2) begin
                if (m_acks) begin
                    m_req = 1'b0;
                    m_leg = 3;
                end
            end else if (!m_acks) begin
                if (m_sent != 16'hFFFF) m_sent++;
                m_leg = 0;
            end
            if (m_acc) begin
                if (in_dest == 4'd0) begin
                    if (m_drop != 16'hFFFF) m_drop++;
                end else m_q.push_back({in_dest, in_payload});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            chk("in_ready", in_ready, m_q.size() < DEPTH);
            chk("dg_req", dg_req, m_req);
            chk("dg_data", dg_data, m_data);
            chk("sent_cnt", sent_cnt, m_sent);
            chk("drop_cnt", drop_cnt, m_drop);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] d, input logic [3:0] p, output bit acc);
        in_valid = 1'b1;
        in_dest = d;
        in_payload = p;
        @(negedge clk);
        acc = in_ready;
        step();
        in_valid = 1'b0;
    endtask

    task automatic push_b(input logic [3:0] d, input logic [3:0] p, output bit acc);
        b_valid = 1'b1;
        b_dest = d;
        b_payload = p;
        @(negedge clk);
        acc = b_ready;
        step();
        b_valid = 1'b0;
    endtask

    task automatic wait_sent(input logic [15:0] tgt, input string name);
        int n = 0;
        while (sent_cnt !== tgt && n < 300) begin
            step();
            n++;
        end
        chk(name, sent_cnt, tgt);
    endtask

    logic [3:0] fd[6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    logic [3:0] fp[6] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hA};
    logic [7:0] exp_full[5] = '{8'h11, 8'h23, 8'h37, 8'h4F, 8'h5F};
    logic [7:0] exp_sim[6] = '{8'h91, 8'h92, 8'h93, 8'hA4, 8'hA5, 8'hA6};

    initial begin
        bit acc;
        int na;
        int base;
        int n;
        step();
        step();
        rst_n = 1'b1;
        at_neg();
        chk("rst in_ready", in_ready, 1);
        chk("rst dg_req", dg_req, 0);
        chk("rst dg_data", dg_data, 0);
        chk("rst sent", sent_cnt, 0);
        chk("rst drop", drop_cnt, 0);
        step();

        // single packet, node acks a few cycles after req
        a_dly = 3;
        push(4'h1, 4'h1, acc);
        chk("single acc", acc, 1);
        at_neg();
        chk("single E0 data", dg_data, 8'h00);
        step();
        at_neg();
        chk("single E1 data", dg_data, 8'h11);
        chk("single E1 req", dg_req, 0);
        step();
        at_neg();
        chk("single E2 req", dg_req, 1);
        wait_sent(16'd1, "single sent");
        chk("single log n", a_log.size(), 1);
        chk("single log", a_log[0], 8'h11);

        // self-addressed word dropped
        push(4'h0, 4'h7, acc);
        chk("drop acc", acc, 1);
        at_neg();
        chk("drop cnt", drop_cnt, 1);
        step();

        // full and backpressure with a stalled node
        a_dly = 0;
        a_hold = 1'b1;
        na = 0;
        for (int i = 0; i < 6; i++) begin
            push(fd[i], fp[i], acc);
            if (acc) na++;
        end
        chk("full accepts", na, 5);
        at_neg();
        chk("full ready", in_ready, 0);
        step();
        a_hold = 1'b0;
        wait_sent(16'd6, "full sent");
        chk("full log n", a_log.size(), 6);
        for (int i = 0; i < 5; i++) chk("full order", a_log[1+i], exp_full[i]);

        // push lands on the same edge as an IDLE pop
        push(4'h9, 4'h1, acc);
        step();
        step();
        push(4'h9, 4'h2, acc);
        repeat (5) step();
        push(4'h9, 4'h3, acc);
        chk("sim acc", acc, 1);
        na = 0;
        for (int i = 0; i < 4; i++) begin
            push(4'hA, 4'(4 + i), acc);
            if (acc) na++;
        end
        chk("sim accepts", na, 3);
        wait_sent(16'd12, "sim sent");
        chk("sim log n", a_log.size(), 12);
        for (int i = 0; i < 6; i++) chk("sim order", a_log[6+i], exp_sim[i]);

        // reset while waiting for ack
        a_hold = 1'b1;
        push(4'h3, 4'h3, acc);
        n = 0;
        while (!dg_req && n < 20) begin
            step();
            n++;
        end
        chk("pre-reset req", dg_req, 1);
        push(4'h4, 4'h4, acc);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        at_neg();
        chk("mid-rst req", dg_req, 0);
        chk("mid-rst data", dg_data, 0);
        chk("mid-rst ready", in_ready, 1);
        chk("mid-rst sent", sent_cnt, 0);
        chk("mid-rst drop", drop_cnt, 0);
        step();
        a_hold = 1'b0;
        base = a_log.size();
        push(4'h9, 4'h9, acc);
        wait_sent(16'd1, "post-rst sent");
        chk("post-rst log n", a_log.size(), base + 1);
        chk("post-rst log", a_log[base], 8'h99);

        // second node: MY_IP=5, 2-bit counters
        push_b(4'h5, 4'h3, acc);
        push_b(4'h6, 4'h2, acc);
        n = 0;
        while (b_sent !== 2'd1 && n < 100) begin
            step();
            n++;
        end
        chk("b drop", b_drop, 1);
        chk("b sent", b_sent, 1);
        chk("b log n", b_log.size(), 1);
        chk("b log", b_log[0], 8'h62);
        na = 0;
        for (int i = 0; i < 5; i++) begin
            push_b(4'h1, 4'(i + 1), acc);
            if (acc) na++;
        end
        chk("b accepts", na, 5);
        n = 0;
        while (b_log.size() < 6 && n < 300) begin
            step();
            n++;
        end
        repeat (12) step();
        chk("b log n2", b_log.size(), 6);
        chk("b last", b_log[5], 8'h15);
        chk("b sent sat", b_sent, 3);
        for (int i = 0; i < 3; i++) push_b(4'h5, 4'h0, acc);
        at_neg();
        chk("b drop sat", b_drop, 3);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
